// File: rtl/ll_pkg.sv
// ----------------------------------------------------------------------------
// ll_pkg
// Shared helpers for the linked-list multi-queue buffer:
//   ptr_width / cnt_width / sel_width : derived index and counter widths
//   free_next_init                     : reset successor of slot j on the
//                                        free list (slot j -> j+1, wrapping)
// ----------------------------------------------------------------------------
package ll_pkg;

    function automatic int ptr_width(input int num_elems);
        return (num_elems < 2) ? 1 : $clog2(num_elems);
    endfunction

    function automatic int cnt_width(input int num_elems);
        return ptr_width(num_elems) + 1;
    endfunction

    function automatic int sel_width(input int num_lists);
        return (num_lists < 2) ? 1 : $clog2(num_lists);
    endfunction

    // Reset free list is the chain 0 -> 1 -> ... -> NUM_ELEMS-1; the wrap on
    // the last slot is a don't-care link that simply keeps the table total.
    function automatic int free_next_init(input int j, input int num_elems);
        return (j + 1) % num_elems;
    endfunction

endpackage

// File: rtl/ll_free_list.sv
// ----------------------------------------------------------------------------
// ll_free_list
// Head/tail bookkeeping of the free-slot chain.
//   clk, rst_n  : clock, asynchronous active-low reset
//   alloc       : a slot is taken from the free head this cycle
//   rel_en      : slot rel_slot is returned to the free tail this cycle
//   free_cnt    : number of slots currently on the free list
//   head_next   : next-pointer of the current free head (read from the shared
//                 next-pointer memory)
//   free_head   : slot handed out by the next allocation
//   free_tail   : last slot on the free list
//   nxt_we/nxt_waddr/nxt_wdata : link write into the shared next-pointer memory
// ----------------------------------------------------------------------------
module ll_free_list
    import ll_pkg::*;
#(
    parameter int NUM_ELEMS = 8,
    parameter int PTR_WIDTH = ptr_width(NUM_ELEMS),
    parameter int CNT_WIDTH = PTR_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc,
    input  logic                 rel_en,
    input  logic [PTR_WIDTH-1:0] rel_slot,
    input  logic [CNT_WIDTH-1:0] free_cnt,
    input  logic [PTR_WIDTH-1:0] head_next,
    output logic [PTR_WIDTH-1:0] free_head,
    output logic [PTR_WIDTH-1:0] free_tail,
    output logic                 nxt_we,
    output logic [PTR_WIDTH-1:0] nxt_waddr,
    output logic [PTR_WIDTH-1:0] nxt_wdata
);

    logic [PTR_WIDTH-1:0] free_head_q, free_head_d;
    logic [PTR_WIDTH-1:0] free_tail_q, free_tail_d;

    always_comb begin
        free_head_d = free_head_q;
        free_tail_d = free_tail_q;
        nxt_we      = 1'b0;
        nxt_waddr   = free_tail_q;
        nxt_wdata   = rel_slot;
        if (rel_en) begin
            if (free_cnt == '0) begin
                // Free list was empty: returned slot is the whole list.
                free_head_d = rel_slot;
                free_tail_d = rel_slot;
            end else begin
                nxt_we      = 1'b1;
                free_tail_d = rel_slot;
                if (alloc) begin
                    // With a single free slot, allocation drains the list and
                    // the slot released in the same cycle becomes the head.
                    free_head_d = (free_cnt == CNT_WIDTH'(1)) ? rel_slot : head_next;
                end
            end
        end else if (alloc) begin
            free_head_d = head_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_head_q <= '0;
            free_tail_q <= PTR_WIDTH'(NUM_ELEMS - 1);
        end else begin
            free_head_q <= free_head_d;
            free_tail_q <= free_tail_d;
        end
    end

    assign free_head = free_head_q;
    assign free_tail = free_tail_q;

endmodule

// File: rtl/linked_list_queue.sv
// ----------------------------------------------------------------------------
// linked_list_queue
// NUM_LISTS FIFO queues sharing a pool of NUM_ELEMS payload slots, chained
// through a next-pointer memory; unused slots live on a free list.
//   clk, rst_n               : clock, asynchronous active-low reset
//   push_valid/push_sel/push_data, push_ready : push handshake into a list
//   pop_en/pop_sel           : pop request; pop_ok says it takes effect
//   pop_data                 : head payload of pop_sel (combinational)
//   empty / full / count / free_count : occupancy status
//   err_push / err_pop       : one-cycle pulses after a rejected request
// ----------------------------------------------------------------------------
module linked_list_queue
    import ll_pkg::*;
#(
    parameter int NUM_ELEMS    = 8,
    parameter int NUM_LISTS    = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_PER_LIST = NUM_ELEMS,
    parameter int PTR_WIDTH    = ptr_width(NUM_ELEMS),
    parameter int CNT_WIDTH    = PTR_WIDTH + 1,
    parameter int SEL_WIDTH    = sel_width(NUM_LISTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_valid,
    input  logic [SEL_WIDTH-1:0]           push_sel,
    input  logic [DATA_WIDTH-1:0]          push_data,
    output logic                           push_ready,
    input  logic                           pop_en,
    input  logic [SEL_WIDTH-1:0]           pop_sel,
    output logic [DATA_WIDTH-1:0]          pop_data,
    output logic                           pop_ok,
    output logic [NUM_LISTS-1:0]           empty,
    output logic                           full,
    output logic [NUM_LISTS*CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0]           free_count,
    output logic                           err_push,
    output logic                           err_pop
);

    localparam logic [SEL_WIDTH:0]   LISTS = (SEL_WIDTH + 1)'(NUM_LISTS);
    localparam logic [CNT_WIDTH-1:0] CAP   = CNT_WIDTH'(MAX_PER_LIST);
    localparam logic [CNT_WIDTH-1:0] ELEMS = CNT_WIDTH'(NUM_ELEMS);

    logic [PTR_WIDTH-1:0]  head_q  [NUM_LISTS];
    logic [PTR_WIDTH-1:0]  head_d  [NUM_LISTS];
    logic [PTR_WIDTH-1:0]  tail_q  [NUM_LISTS];
    logic [PTR_WIDTH-1:0]  tail_d  [NUM_LISTS];
    logic [CNT_WIDTH-1:0]  cnt_q   [NUM_LISTS];
    logic [CNT_WIDTH-1:0]  cnt_d   [NUM_LISTS];
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic                  err_push_q, err_push_d;
    logic                  err_pop_q, err_pop_d;

    logic [PTR_WIDTH-1:0]  nxt_q   [NUM_ELEMS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_ELEMS];

    logic                  push_sel_ok, pop_sel_ok;
    logic [SEL_WIDTH-1:0]  push_idx, pop_idx;
    logic                  push_acc;
    logic [PTR_WIDTH-1:0]  pop_slot;
    logic [NUM_LISTS-1:0]  push_hit, pop_hit;
    logic                  link_we;

    logic [PTR_WIDTH-1:0]  free_head, free_tail;
    logic                  fl_we;
    logic [PTR_WIDTH-1:0]  fl_waddr, fl_wdata;

    // Out-of-range selects are steered to list 0 for reads only; they are
    // never accepted, so no state is touched through the steered index.
    assign push_sel_ok = ({1'b0, push_sel} < LISTS);
    assign pop_sel_ok  = ({1'b0, pop_sel} < LISTS);
    assign push_idx    = push_sel_ok ? push_sel : '0;
    assign pop_idx     = pop_sel_ok ? pop_sel : '0;

    // Readiness looks at registered state only, so a same-cycle pop can never
    // open room for a push.
    assign full       = (total_q == ELEMS);
    assign push_ready = !full && (cnt_q[push_idx] < CAP) && push_sel_ok;
    assign push_acc   = push_valid && push_ready;
    assign pop_ok     = pop_en && pop_sel_ok && (cnt_q[pop_idx] != '0);
    assign pop_slot   = head_q[pop_idx];
    assign pop_data   = data_q[pop_slot];

    // Link the allocated slot behind the current tail of a non-empty list.
    assign link_we = push_acc && (cnt_q[push_idx] != '0);

    ll_free_list #(
        .NUM_ELEMS (NUM_ELEMS),
        .PTR_WIDTH (PTR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_free_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc     (push_acc),
        .rel_en    (pop_ok),
        .rel_slot  (pop_slot),
        .free_cnt  (free_count),
        .head_next (nxt_q[free_head]),
        .free_head (free_head),
        .free_tail (free_tail),
        .nxt_we    (fl_we),
        .nxt_waddr (fl_waddr),
        .nxt_wdata (fl_wdata)
    );

    always_comb begin
        for (int i = 0; i < NUM_LISTS; i++) begin
            push_hit[i] = push_acc && (push_idx == SEL_WIDTH'(i));
            pop_hit[i]  = pop_ok && (pop_idx == SEL_WIDTH'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LISTS; i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            cnt_d[i]  = cnt_q[i];
            if (push_hit[i] && pop_hit[i]) begin
                // Popping the only entry: the stale next pointer of the old
                // head is meaningless, the pushed slot becomes the head.
                head_d[i] = (cnt_q[i] == CNT_WIDTH'(1)) ? free_head : nxt_q[head_q[i]];
                tail_d[i] = free_head;
            end else if (push_hit[i]) begin
                if (cnt_q[i] == '0) begin
                    head_d[i] = free_head;
                end
                tail_d[i] = free_head;
                cnt_d[i]  = cnt_q[i] + CNT_WIDTH'(1);
            end else if (pop_hit[i]) begin
                head_d[i] = nxt_q[head_q[i]];
                cnt_d[i]  = cnt_q[i] - CNT_WIDTH'(1);
            end
        end

        total_d = total_q;
        if (push_acc && !pop_ok) begin
            total_d = total_q + CNT_WIDTH'(1);
        end else if (!push_acc && pop_ok) begin
            total_d = total_q - CNT_WIDTH'(1);
        end

        err_push_d = push_valid && !push_ready;
        err_pop_d  = pop_en && !pop_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LISTS; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            total_q    <= '0;
            err_push_q <= 1'b0;
            err_pop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LISTS; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            total_q    <= total_d;
            err_push_q <= err_push_d;
            err_pop_q  <= err_pop_d;
        end
    end

    // Next-pointer memory: the list-tail link targets a slot in use and the
    // free-tail link targets a free slot, so the two writes never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_ELEMS; j++) begin
                nxt_q[j] <= PTR_WIDTH'(free_next_init(j, NUM_ELEMS));
            end
        end else begin
            if (link_we) begin
                nxt_q[tail_q[push_idx]] <= free_head;
            end
            if (fl_we) begin
                nxt_q[fl_waddr] <= fl_wdata;
            end
        end
    end

    // Payload memory carries no reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            data_q[free_head] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LISTS; i++) begin
            empty[i]                           = (cnt_q[i] == '0);
            count[i*CNT_WIDTH +: CNT_WIDTH]    = cnt_q[i];
        end
    end

    assign free_count = ELEMS - total_q;
    assign err_push   = err_push_q;
    assign err_pop    = err_pop_q;

endmodule
